// File: rtl/pe_scatter_pkg.sv
// Shared constants for the PE-array stream distributor.
// Mode encodings for the rr_mode input.
package pe_scatter_pkg;
    localparam logic MODE_DIRECTED = 1'b0;
    localparam logic MODE_SCATTER  = 1'b1;
endpackage

// File: rtl/pe_scatter_slot.sv
// One-entry output register for a single scatter channel.
// Supports load, valid/ready drain, and load-during-drain for full throughput.
module pe_scatter_slot
    import pe_scatter_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_ready,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data
);
    logic             r_valid;
    logic [WIDTH-1:0] r_data;

    // A load wins over a drain, so a drain+load cycle keeps the slot valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
        end else if (r_valid && i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
endmodule

// File: rtl/pe_scatter.sv
// Registered 1-to-N stream distributor: one input stream steered to per-lane
// one-entry output slots, by select tag (directed) or round-robin pointer (scatter).
module pe_scatter
    import pe_scatter_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int SEL_WIDTH = 3
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [WIDTH-1:0]            in_data,
    input  logic [SEL_WIDTH-1:0]        in_sel,
    input  logic                        rr_mode,
    input  logic                        rr_clr,
    output logic [(1<<SEL_WIDTH)-1:0]   out_valid,
    input  logic [(1<<SEL_WIDTH)-1:0]   out_ready,
    output logic [WIDTH-1:0]            out_data [(1<<SEL_WIDTH)-1:0],
    output logic [SEL_WIDTH-1:0]        rr_ptr
);
    localparam int N = 1 << SEL_WIDTH;

    logic [SEL_WIDTH-1:0] r_ptr;
    logic [SEL_WIDTH-1:0] w_dest;
    logic                 w_in_ready;
    logic                 w_accept;
    logic [N-1:0]         w_load;

    // Handshake: a beat transfers on a cycle where in_valid && in_ready. in_ready
    // is 1 when the destination slot is empty or draining this cycle; it never
    // depends on in_valid, so the producer holds data/sel while stalled.
    assign w_dest     = (rr_mode == MODE_SCATTER) ? r_ptr : in_sel;
    assign w_in_ready = !out_valid[w_dest] || out_ready[w_dest];
    assign w_accept   = in_valid && w_in_ready;
    assign in_ready   = w_in_ready;

    // The clear wins over an advance; the beat in that cycle used the old pointer.
    always_ff @(posedge clk) begin
        if (rst || rr_clr) begin
            r_ptr <= '0;
        end else if (w_accept && rr_mode == MODE_SCATTER) begin
            r_ptr <= r_ptr + 1'b1;
        end
    end

    assign rr_ptr = r_ptr;

    for (genvar i = 0; i < N; i++) begin : g_slot
        assign w_load[i] = w_accept && (w_dest == SEL_WIDTH'(i));

        pe_scatter_slot #(
            .WIDTH (WIDTH)
        ) u_slot (
            .clk     (clk),
            .rst     (rst),
            .i_load  (w_load[i]),
            .i_data  (in_data),
            .i_ready (out_ready[i]),
            .o_valid (out_valid[i]),
            .o_data  (out_data[i])
        );
    end
endmodule
